ram_access_ctrl: RTL and testbench



---
 rtl/ram_access_ctrl_pkg.sv | 34 +++
 rtl/ram_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg
// Shared widths, FSM state encodings and helpers for the asynchronous SRAM
// access controller that sits behind the MEM stage.
package ram_access_ctrl_pkg;

    // Default bus widths used across the memory path
    localparam int DATA_BUS_W       = 16;
    localparam int RAM_ADDR_BUS_W   = 18;

    // FSM state register and wait counter widths
    localparam int RAM_CTRL_STATE_W = 2;
    localparam int RAM_CTRL_WAIT_W  = 4;

    typedef logic [RAM_CTRL_STATE_W-1:0] ram_ctrl_state_t;
    typedef logic [RAM_CTRL_WAIT_W-1:0]  ram_ctrl_wait_t;

    // State encodings, kept as plain constants so older code can share them
    localparam logic [1:0] RAM_ST_IDLE   = 2'd0;
    localparam logic [1:0] RAM_ST_SETUP  = 2'd1;
    localparam logic [1:0] RAM_ST_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ST_HOLD   = 2'd3;

    // Reload value for the ACCESS down-counter. The counter runs from
    // cycles-1 down to 0, so ACCESS lasts exactly 'cycles' clocks. Values
    // outside 1..15 are clamped so the counter never wraps.
    function automatic ram_ctrl_wait_t wait_reload(input int cycles);
        int clamped;
        clamped = cycles;
        if (clamped < 1)  clamped = 1;
        if (clamped > 15) clamped = 15;
        return ram_ctrl_wait_t'(clamped - 1);
    endfunction

endpackage

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Sequences one read or write per transaction onto an external asynchronous
// SRAM using SETUP -> ACCESS (WAIT_CYCLES) -> HOLD phases. Every pin and
// status output comes straight from a flop, so nothing on the request side
// reaches the board combinationally. HOLD can accept the next request, which
// keeps back-to-back transactions free of idle bubbles.
//
// Optional feature macro: RAM_ACCESS_CTRL_WRITE_FWD_EN
//   When defined, the last accepted write (address + data) is remembered and
//   a read of that same address completes from the register in one cycle
//   without touching the SRAM. When undefined, every read goes to the SRAM.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int DATA_W      = DATA_BUS_W,
    parameter int ADDR_W      = RAM_ADDR_BUS_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dq_i,
    output logic [DATA_W-1:0] ram_dq_o,
    output logic              ram_dq_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    localparam ram_ctrl_wait_t WAIT_LOAD = wait_reload(WAIT_CYCLES);

    ram_ctrl_state_t state;
    ram_ctrl_wait_t  wait_cnt;
    logic            lat_we;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_rd_data;

`ifdef RAM_ACCESS_CTRL_WRITE_FWD_EN
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    // Remember the most recently accepted write for read forwarding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (ready && req && we) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= addr;
            fwd_data  <= wdata;
        end
    end

    assign fwd_hit     = !we && fwd_valid && (addr == fwd_addr);
    assign fwd_rd_data = fwd_data;
`else
    assign fwd_hit     = 1'b0;
    assign fwd_rd_data = '0;
`endif

    // Main sequencer: state, wait counter and all registered SRAM/status pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RAM_ST_IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_dq_o  <= '0;
            ram_dq_oe <= 1'b0;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                RAM_ST_IDLE, RAM_ST_HOLD: begin
                    if (req && fwd_hit) begin
                        // Read satisfied from the forwarding register
                        state     <= RAM_ST_HOLD;
                        lat_we    <= 1'b0;
                        done      <= 1'b1;
                        rdata     <= fwd_rd_data;
                        ready     <= 1'b1;
                        ram_ce_n  <= 1'b1;
                        ram_oe_n  <= 1'b1;
                        ram_we_n  <= 1'b1;
                        ram_dq_oe <= 1'b0;
                    end else if (req) begin
                        // Accept and present address (and write data) in SETUP
                        state     <= RAM_ST_SETUP;
                        lat_we    <= we;
                        ready     <= 1'b0;
                        ram_addr  <= addr;
                        ram_ce_n  <= 1'b0;
                        ram_we_n  <= 1'b1;
                        ram_oe_n  <= we;
                        ram_dq_oe <= we;
                        if (we) begin
                            ram_dq_o <= wdata;
                        end
                    end else begin
                        state     <= RAM_ST_IDLE;
                        ready     <= 1'b1;
                        ram_ce_n  <= 1'b1;
                        ram_oe_n  <= 1'b1;
                        ram_we_n  <= 1'b1;
                        ram_dq_oe <= 1'b0;
                    end
                end

                RAM_ST_SETUP: begin
                    state    <= RAM_ST_ACCESS;
                    wait_cnt <= WAIT_LOAD;
                    if (lat_we) begin
                        ram_we_n <= 1'b0;
                    end else begin
                        ram_oe_n <= 1'b0;
                    end
                end

                RAM_ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        state    <= RAM_ST_HOLD;
                        done     <= 1'b1;
                        ready    <= 1'b1;
                        ram_we_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        if (!lat_we) begin
                            rdata <= ram_dq_i;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= RAM_ST_IDLE;
                    ready     <= 1'b1;
                    ram_ce_n  <= 1'b1;
                    ram_oe_n  <= 1'b1;
                    ram_we_n  <= 1'b1;
                    ram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Directed bench for ram_access_ctrl. Instance A runs with WAIT_CYCLES=1,
// instance B with WAIT_CYCLES=3. Each has a small SRAM model indexed by the
// low 8 address bits, preloaded with 16'hC000 | index.
module tb_ram_access_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic        a_req, a_we, a_ready, a_done, a_dq_oe, a_ce_n, a_oe_n, a_we_n;
    logic [17:0] a_addr, a_ram_addr;
    logic [15:0] a_wdata, a_rdata, a_dq_i, a_dq_o;

    logic        b_req, b_we, b_ready, b_done, b_dq_oe, b_ce_n, b_oe_n, b_we_n;
    logic [17:0] b_addr, b_ram_addr;
    logic [15:0] b_wdata, b_rdata, b_dq_i, b_dq_o;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    int clear_gen = 0;
    int seen_gen  = 0;
    int viol      = 0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.DATA_W(16), .ADDR_W(18), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr),
        .wdata(a_wdata), .ready(a_ready), .done(a_done), .rdata(a_rdata),
        .ram_addr(a_ram_addr), .ram_dq_i(a_dq_i), .ram_dq_o(a_dq_o),
        .ram_dq_oe(a_dq_oe), .ram_ce_n(a_ce_n), .ram_oe_n(a_oe_n),
        .ram_we_n(a_we_n)
    );

    ram_access_ctrl #(.DATA_W(16), .ADDR_W(18), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr),
        .wdata(b_wdata), .ready(b_ready), .done(b_done), .rdata(b_rdata),
        .ram_addr(b_ram_addr), .ram_dq_i(b_dq_i), .ram_dq_o(b_dq_o),
        .ram_dq_oe(b_dq_oe), .ram_ce_n(b_ce_n), .ram_oe_n(b_oe_n),
        .ram_we_n(b_we_n)
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'hC000 | 16'(i);
    endfunction

    // SRAM models drive read data only while the chip and output are enabled
    assign a_dq_i = (!a_ce_n && !a_oe_n) ? mem_a[a_ram_addr[7:0]] : 16'h0000;
    assign b_dq_i = (!b_ce_n && !b_oe_n) ? mem_b[b_ram_addr[7:0]] : 16'h0000;

    // SRAM model writes, model clearing and strobe-overlap monitoring
    always @(negedge clk) begin
        if (seen_gen != clear_gen) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] = init_word(i);
                mem_b[i] = init_word(i);
            end
            seen_gen = clear_gen;
        end
        if (!a_ce_n && !a_we_n && a_dq_oe) mem_a[a_ram_addr[7:0]] = a_dq_o;
        if (!b_ce_n && !b_we_n && b_dq_oe) mem_b[b_ram_addr[7:0]] = b_dq_o;
        if (!a_we_n && !a_oe_n) viol++;
        if (a_dq_oe && !a_oe_n) viol++;
        if (!b_we_n && !b_oe_n) viol++;
        if (b_dq_oe && !b_oe_n) viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_models();
        clear_gen = clear_gen + 1;
        @(negedge clk);
        #1;
    endtask

    // One transaction on instance A with pin activity counted per cycle
    task automatic run_txn_a(input logic w, input logic [17:0] ad, input logic [15:0] wd,
                             output int lat, output int we_lo, output int oe_lo,
                             output int dqoe_hi, output int ce_lo,
                             output logic [17:0] setup_addr, output logic [15:0] setup_dq,
                             output logic [15:0] rd);
        a_req = 1'b1; a_we = w; a_addr = ad; a_wdata = wd;
        lat = 0; we_lo = 0; oe_lo = 0; dqoe_hi = 0; ce_lo = 0;
        setup_addr = '0; setup_dq = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                a_req = 1'b0;
                setup_addr = a_ram_addr;
                setup_dq = a_dq_o;
            end
            if (!a_we_n) we_lo++;
            if (!a_oe_n) oe_lo++;
            if (a_dq_oe) dqoe_hi++;
            if (!a_ce_n) ce_lo++;
            if (a_done) begin
                lat = i;
                break;
            end
        end
        rd = a_rdata;
        tick();
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        reset_models();
        tick(); tick();
        rst = 1'b0;
        tick();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        if (a_ce_n !== 1'b1 || a_oe_n !== 1'b1 || a_we_n !== 1'b1 || a_dq_oe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_pins ce_n=%b oe_n=%b we_n=%b dq_oe=%b want 1110", a_ce_n, a_oe_n, a_we_n, a_dq_oe);
        end
        checks++;
        if (a_ready !== 1'b1 || a_done !== 1'b0 || a_rdata !== 16'h0 || a_ram_addr !== 18'h0 || a_dq_o !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_status ready=%b done=%b rdata=%h addr=%h dq_o=%h want 1/0/0/0/0", a_ready, a_done, a_rdata, a_ram_addr, a_dq_o);
        end
        checks++;
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_ready !== 1'b1 || a_done !== 1'b0 || a_ce_n !== 1'b1 || a_oe_n !== 1'b1 || a_we_n !== 1'b1) bad++;
            if (b_ready !== 1'b1 || b_done !== 1'b0 || b_ce_n !== 1'b1 || b_oe_n !== 1'b1 || b_we_n !== 1'b1) bad++;
        end
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL idle_quiet bad_cycles=%0d want 0", bad);
        end
        checks++;
    endtask

    task automatic test_single_write();
        int lat, wl, ol, dh, cl;
        logic [17:0] sa;
        logic [15:0] sd, rd;
        run_txn_a(1'b1, 18'h00123, 16'hBEEF, lat, wl, ol, dh, cl, sa, sd, rd);
        if (lat !== 3) begin failures++; $display("[TB] FAIL wr_latency got=%0d want 3", lat); end
        checks++;
        if (sa !== 18'h00123 || sd !== 16'hBEEF) begin
            failures++; $display("[TB] FAIL wr_setup addr=%h dq=%h want 00123/beef", sa, sd);
        end
        checks++;
        if (wl !== 1 || dh !== 3 || ol !== 0 || cl !== 3) begin
            failures++; $display("[TB] FAIL wr_strobes we_lo=%0d dqoe=%0d oe_lo=%0d ce_lo=%0d want 1/3/0/3", wl, dh, ol, cl);
        end
        checks++;
        if (mem_a[8'h23] !== 16'hBEEF) begin
            failures++; $display("[TB] FAIL wr_mem got=%h want beef", mem_a[8'h23]);
        end
        checks++;
        if (a_ce_n !== 1'b1 || a_dq_oe !== 1'b0 || a_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL wr_idle ce_n=%b dq_oe=%b ready=%b want 1/0/1", a_ce_n, a_dq_oe, a_ready);
        end
        checks++;
        // Second write elsewhere so the following read cannot be forwarded
        run_txn_a(1'b1, 18'h00124, 16'h0F0F, lat, wl, ol, dh, cl, sa, sd, rd);
        if (mem_a[8'h24] !== 16'h0F0F) begin
            failures++; $display("[TB] FAIL wr2_mem got=%h want 0f0f", mem_a[8'h24]);
        end
        checks++;
    endtask

    task automatic test_single_read();
        int lat, wl, ol, dh, cl;
        logic [17:0] sa;
        logic [15:0] sd, rd;
        run_txn_a(1'b0, 18'h00123, 16'h0000, lat, wl, ol, dh, cl, sa, sd, rd);
        if (lat !== 3 || rd !== 16'hBEEF) begin
            failures++; $display("[TB] FAIL rd_basic lat=%0d rdata=%h want 3/beef", lat, rd);
        end
        checks++;
        if (ol !== 2 || wl !== 0 || dh !== 0 || sa !== 18'h00123) begin
            failures++; $display("[TB] FAIL rd_strobes oe_lo=%0d we_lo=%0d dqoe=%0d addr=%h want 2/0/0/00123", ol, wl, dh, sa);
        end
        checks++;
        tick(); tick();
        if (a_rdata !== 16'hBEEF || a_done !== 1'b0) begin
            failures++; $display("[TB] FAIL rd_hold rdata=%h done=%b want beef/0", a_rdata, a_done);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int first_done, total, ce_hi;
        logic hold_dqoe, rs_dqoe, rs_oe_n;
        logic [15:0] hold_dq;
        logic [17:0] rs_addr;
        first_done = 0; total = 0; ce_hi = 0;
        hold_dqoe = 0; hold_dq = '0; rs_dqoe = 1; rs_oe_n = 1; rs_addr = '0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 18'h00056; b_wdata = 16'h1357;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) b_req = 1'b0;
            if (b_ce_n) ce_hi++;
            if (first_done != 0 && i == first_done + 1) begin
                rs_dqoe = b_dq_oe; rs_oe_n = b_oe_n; rs_addr = b_ram_addr;
                b_req = 1'b0;
            end
            if (b_done) begin
                if (first_done == 0) begin
                    first_done = i;
                    hold_dqoe = b_dq_oe; hold_dq = b_dq_o;
                    b_req = 1'b1; b_we = 1'b0; b_addr = 18'h00055;
                end else begin
                    total = i;
                    break;
                end
            end
        end
        b_req = 1'b0;
        if (first_done !== 5 || total !== 10) begin
            failures++; $display("[TB] FAIL b2b_timing first=%0d total=%0d want 5/10", first_done, total);
        end
        checks++;
        if (hold_dqoe !== 1'b1 || hold_dq !== 16'h1357) begin
            failures++; $display("[TB] FAIL b2b_wr_hold dq_oe=%b dq=%h want 1/1357", hold_dqoe, hold_dq);
        end
        checks++;
        if (rs_dqoe !== 1'b0 || rs_oe_n !== 1'b0 || rs_addr !== 18'h00055 || ce_hi !== 0) begin
            failures++; $display("[TB] FAIL b2b_turn dq_oe=%b oe_n=%b addr=%h ce_hi=%0d want 0/0/00055/0", rs_dqoe, rs_oe_n, rs_addr, ce_hi);
        end
        checks++;
        if (b_rdata !== 16'hC055 || mem_b[8'h56] !== 16'h1357) begin
            failures++; $display("[TB] FAIL b2b_data rdata=%h mem=%h want c055/1357", b_rdata, mem_b[8'h56]);
        end
        checks++;
        tick();
    endtask

    task automatic test_reset_mid_access();
        int lat, wl, ol, dh, cl, dn;
        logic [17:0] sa;
        logic [15:0] sd, rd;
        a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00040; a_wdata = 16'h1234;
        tick();
        a_req = 1'b0;
        tick();
        if (a_we_n !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_access_we got=%b want 0", a_we_n);
        end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (a_we_n !== 1'b1 || a_ce_n !== 1'b1 || a_dq_oe !== 1'b0 || a_done !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_reset_pins we_n=%b ce_n=%b dq_oe=%b done=%b want 1/1/0/0", a_we_n, a_ce_n, a_dq_oe, a_done);
        end
        checks++;
        tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_done) dn++;
        end
        if (dn !== 0 || a_rdata !== 16'h0000) begin
            failures++; $display("[TB] FAIL mid_reset_after done_cycles=%0d rdata=%h want 0/0000", dn, a_rdata);
        end
        checks++;
        reset_models();
        run_txn_a(1'b0, 18'h00040, 16'h0000, lat, wl, ol, dh, cl, sa, sd, rd);
        if (lat !== 3 || rd !== 16'hC040) begin
            failures++; $display("[TB] FAIL mid_reset_read lat=%0d rdata=%h want 3/c040", lat, rd);
        end
        checks++;
    endtask

    task automatic test_forward();
        int lat, wl, ol, dh, cl;
        logic [17:0] sa;
        logic [15:0] sd, rd;
        run_txn_a(1'b1, 18'h00010, 16'h5A5A, lat, wl, ol, dh, cl, sa, sd, rd);
        run_txn_a(1'b0, 18'h00010, 16'h0000, lat, wl, ol, dh, cl, sa, sd, rd);
`ifdef RAM_ACCESS_CTRL_WRITE_FWD_EN
        if (lat !== 1 || cl !== 0 || ol !== 0 || rd !== 16'h5A5A) begin
            failures++; $display("[TB] FAIL fwd_hit lat=%0d ce_lo=%0d oe_lo=%0d rdata=%h want 1/0/0/5a5a", lat, cl, ol, rd);
        end
`else
        if (lat !== 3 || cl !== 3 || ol !== 2 || rd !== 16'h5A5A) begin
            failures++; $display("[TB] FAIL same_addr_read lat=%0d ce_lo=%0d oe_lo=%0d rdata=%h want 3/3/2/5a5a", lat, cl, ol, rd);
        end
`endif
        checks++;
        run_txn_a(1'b0, 18'h00011, 16'h0000, lat, wl, ol, dh, cl, sa, sd, rd);
        if (lat !== 3 || cl !== 3 || ol !== 2 || rd !== 16'hC011) begin
            failures++; $display("[TB] FAIL other_addr_read lat=%0d ce_lo=%0d oe_lo=%0d rdata=%h want 3/3/2/c011", lat, cl, ol, rd);
        end
        checks++;
    endtask

    task automatic test_invariants();
        if (viol !== 0) begin
            failures++; $display("[TB] FAIL strobe_overlap count=%0d want 0", viol);
        end
        checks++;
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_reset_mid_access();
        test_forward();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
